// File: rtl/usb_rx_crc16_check.sv
// usb_rx_crc16_check: serial USB CRC-16 checker for the RX data field.
// Runs the CRC-16 LFSR (poly 8005, init FFFF) over data + received CRC,
// LSB-first, and compares the residual against 16'h800D at end of packet.
// Optional length check enabled by defining RX_CRC_LEN_CHECK_EN (adds len_error).
module usb_rx_crc16_check #(
    parameter int unsigned BYTE_CNT_W = 11
) (
    input  logic                  clk,
    input  logic                  n_rst,
    input  logic                  pkt_start,
    input  logic                  bit_valid,
    input  logic                  bit_in,
    input  logic                  pkt_end,
    output logic                  busy,
    output logic                  crc_done,
    output logic                  crc_ok,
    output logic                  crc_error,
    output logic [15:0]           crc_value,
    output logic [BYTE_CNT_W-1:0] byte_count
`ifdef RX_CRC_LEN_CHECK_EN
    ,
    output logic                  len_error
`endif
);

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        DONE
    } state_t;

    localparam logic [15:0] CRC_INIT     = 16'hFFFF;
    localparam logic [15:0] CRC_POLY     = 16'h8005;
    localparam logic [15:0] CRC_RESIDUAL = 16'h800D;

    state_t                state_q, state_d;
    logic [15:0]           crc_q, crc_d;
    logic [2:0]            bit_cnt_q, bit_cnt_d;
    logic [BYTE_CNT_W-1:0] byte_cnt_q, byte_cnt_d;
    logic                  done_q, done_d;
    logic                  ok_q, ok_d;
    logic                  err_q, err_d;
    logic                  fb;
    logic                  len_bad;
`ifdef RX_CRC_LEN_CHECK_EN
    logic                  len_err_q, len_err_d;
`endif

    // Next-state, LFSR, counters and result logic.
    always_comb begin
        state_d    = state_q;
        crc_d      = crc_q;
        bit_cnt_d  = bit_cnt_q;
        byte_cnt_d = byte_cnt_q;
        done_d     = 1'b0;
        ok_d       = ok_q;
        err_d      = err_q;
        len_bad    = 1'b0;
`ifdef RX_CRC_LEN_CHECK_EN
        len_err_d  = len_err_q;
`endif
        fb         = crc_q[15] ^ bit_in;

        if (pkt_start) begin
            // Restart from any state; a bit arriving in this cycle is dropped.
            state_d    = ACCUM;
            crc_d      = CRC_INIT;
            bit_cnt_d  = '0;
            byte_cnt_d = '0;
            ok_d       = 1'b0;
            err_d      = 1'b0;
`ifdef RX_CRC_LEN_CHECK_EN
            len_err_d  = 1'b0;
`endif
        end else if (state_q == ACCUM) begin
            if (bit_valid) begin
                crc_d     = {crc_q[14:0], 1'b0} ^ (fb ? CRC_POLY : '0);
                bit_cnt_d = bit_cnt_q + 3'd1;
                if (bit_cnt_q == 3'd7 && byte_cnt_q != '1) begin
                    byte_cnt_d = byte_cnt_q + BYTE_CNT_W'(1);
                end
            end
            if (pkt_end) begin
                // Judged on the updated values so a bit sharing the pkt_end cycle counts.
`ifdef RX_CRC_LEN_CHECK_EN
                len_bad   = (bit_cnt_d != 3'd0) || (byte_cnt_d < BYTE_CNT_W'(2));
                len_err_d = len_bad;
`endif
                state_d = DONE;
                done_d  = 1'b1;
                ok_d    = (crc_d == CRC_RESIDUAL) && !len_bad;
                err_d   = !ok_d;
            end
        end
    end

    // State register with asynchronous active-low reset.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q    <= IDLE;
            crc_q      <= CRC_INIT;
            bit_cnt_q  <= '0;
            byte_cnt_q <= '0;
            done_q     <= 1'b0;
            ok_q       <= 1'b0;
            err_q      <= 1'b0;
`ifdef RX_CRC_LEN_CHECK_EN
            len_err_q  <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            crc_q      <= crc_d;
            bit_cnt_q  <= bit_cnt_d;
            byte_cnt_q <= byte_cnt_d;
            done_q     <= done_d;
            ok_q       <= ok_d;
            err_q      <= err_d;
`ifdef RX_CRC_LEN_CHECK_EN
            len_err_q  <= len_err_d;
`endif
        end
    end

    assign busy       = (state_q == ACCUM);
    assign crc_done   = done_q;
    assign crc_ok     = ok_q;
    assign crc_error  = err_q;
    assign crc_value  = crc_q;
    assign byte_count = byte_cnt_q;
`ifdef RX_CRC_LEN_CHECK_EN
    assign len_error  = len_err_q;
`endif

endmodule

// File: tb/tb_usb_rx_crc16_check.sv
// Testbench for usb_rx_crc16_check. Expected results come from a polynomial
// long-division CRC model; length checks follow RX_CRC_LEN_CHECK_EN.
module tb_usb_rx_crc16_check;

    localparam int BW = 11;
    typedef bit bitq_t[$];

    logic          clk = 1'b0;
    logic          n_rst;
    logic          pkt_start, bit_valid, bit_in, pkt_end;
    logic          busy, crc_done, crc_ok, crc_error;
    logic [15:0]   crc_value;
    logic [BW-1:0] byte_count;
    logic          len_error_w;

    int checks = 0;
    int errors = 0;

    usb_rx_crc16_check #(.BYTE_CNT_W(BW)) dut (
        .clk        (clk),
        .n_rst      (n_rst),
        .pkt_start  (pkt_start),
        .bit_valid  (bit_valid),
        .bit_in     (bit_in),
        .pkt_end    (pkt_end),
        .busy       (busy),
        .crc_done   (crc_done),
        .crc_ok     (crc_ok),
        .crc_error  (crc_error),
        .crc_value  (crc_value),
        .byte_count (byte_count)
`ifdef RX_CRC_LEN_CHECK_EN
        ,
        .len_error  (len_error_w)
`endif
    );

`ifndef RX_CRC_LEN_CHECK_EN
    assign len_error_w = 1'b0;
`endif

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Remainder of (FFFF * x^n + M(x) * x^16) mod (x^16 + x^15 + x^2 + 1),
    // first bit of the stream being the highest-degree coefficient.
    function automatic logic [15:0] crc_model(input bitq_t q);
        int          n = q.size();
        bit          a[];
        logic [16:0] poly = 17'h18005;
        logic [15:0] r;
        a = new[n + 16];
        for (int i = 0; i < n + 16; i++) a[i] = (i < n) ? q[i] : 1'b0;
        for (int i = 0; i < 16; i++) a[i] = a[i] ^ 1'b1;
        for (int i = 0; i < n; i++)
            if (a[i])
                for (int j = 0; j < 17; j++) a[i + j] = a[i + j] ^ poly[16 - j];
        for (int k = 0; k < 16; k++) r[15 - k] = a[n + k];
        return r;
    endfunction

    function automatic logic exp_len_err(input int n);
`ifdef RX_CRC_LEN_CHECK_EN
        return ((n % 8) != 0) || ((n / 8) < 2);
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [BW-1:0] exp_bytes(input int n);
        int m = (1 << BW) - 1;
        return BW'((n / 8 > m) ? m : n / 8);
    endfunction

    function automatic logic exp_ok(input bitq_t q);
        return (crc_model(q) == 16'h800D) && !exp_len_err(q.size());
    endfunction

    // Random data bytes followed by the inverted CRC, highest-degree bit first.
    function automatic bitq_t make_good(input int nbytes);
        bitq_t       q;
        logic [15:0] c;
        for (int i = 0; i < nbytes * 8; i++) q.push_back(bit'($urandom_range(1)));
        c = ~crc_model(q);
        for (int k = 15; k >= 0; k--) q.push_back(c[k]);
        return q;
    endfunction

    // Drives one packet and captures what the DUT shows in the result cycle.
    task automatic run_pkt(input bitq_t bits, input int gap_pct, input bit merge_end,
                           output int n_done, output logic [15:0] o_crc,
                           output logic o_ok, output logic o_err, output logic o_lerr,
                           output logic [BW-1:0] o_bytes, output logic o_busy_ok,
                           output logic o_done_after);
        bit merge;
        merge     = merge_end && (bits.size() > 0);
        n_done    = 0;
        pkt_start = 1'b1;
        tick();
        pkt_start = 1'b0;
        o_busy_ok = (busy === 1'b1);
        for (int i = 0; i < bits.size(); i++) begin
            while ($urandom_range(99) < gap_pct) begin
                bit_valid = 1'b0;
                tick();
                n_done += int'(crc_done);
                o_busy_ok &= (busy === 1'b1);
            end
            bit_valid = 1'b1;
            bit_in    = bits[i];
            if (merge && i == bits.size() - 1) pkt_end = 1'b1;
            tick();
            n_done += int'(crc_done);
            if (!(merge && i == bits.size() - 1)) o_busy_ok &= (busy === 1'b1);
        end
        if (!merge) begin
            bit_valid = 1'b0;
            pkt_end   = 1'b1;
            tick();
            n_done += int'(crc_done);
        end
        bit_valid = 1'b0;
        pkt_end   = 1'b0;
        o_busy_ok &= (busy === 1'b0);
        o_crc   = crc_value;
        o_ok    = crc_ok;
        o_err   = crc_error;
        o_lerr  = len_error_w;
        o_bytes = byte_count;
        tick();
        o_done_after = crc_done;
        n_done += int'(crc_done);
    endtask

    task automatic test_reset();
        n_rst = 1'b0; pkt_start = 1'b0; bit_valid = 1'b0; bit_in = 1'b0; pkt_end = 1'b0;
        tick(); tick();
        n_rst = 1'b1;
        tick();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (crc_done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", crc_done); end
        checks++; if (crc_ok !== 1'b0 || crc_error !== 1'b0) begin errors++; $display("FAIL reset_result got ok=%b err=%b want 0/0", crc_ok, crc_error); end
        checks++; if (crc_value !== 16'hFFFF) begin errors++; $display("FAIL reset_crc got %h want ffff", crc_value); end
        checks++; if (byte_count !== '0) begin errors++; $display("FAIL reset_bytes got %0d want 0", byte_count); end
        checks++; if (len_error_w !== 1'b0) begin errors++; $display("FAIL reset_len got %b want 0", len_error_w); end
    endtask

    task automatic test_zero_len();
        bitq_t q; int nd; logic [15:0] c; logic ok, err, le, bo, da; logic [BW-1:0] by;
        for (int i = 0; i < 16; i++) q.push_back(1'b0);
        run_pkt(q, 0, 1'b0, nd, c, ok, err, le, by, bo, da);
        checks++; if (c !== 16'h800D) begin errors++; $display("FAIL zero_crc got %h want 800d", c); end
        checks++; if (c !== crc_model(q)) begin errors++; $display("FAIL zero_model got %h want %h", c, crc_model(q)); end
        checks++; if (ok !== 1'b1 || err !== 1'b0) begin errors++; $display("FAIL zero_result got ok=%b err=%b want 1/0", ok, err); end
        checks++; if (nd !== 1 || da !== 1'b0) begin errors++; $display("FAIL zero_done got pulses=%0d after=%b want 1/0", nd, da); end
        checks++; if (by !== BW'(2)) begin errors++; $display("FAIL zero_bytes got %0d want 2", by); end
        checks++; if (bo !== 1'b1) begin errors++; $display("FAIL zero_busy got %b want 1", bo); end
    endtask

    task automatic test_last_bit_one();
        bitq_t q; int nd; logic [15:0] c; logic ok, err, le, bo, da; logic [BW-1:0] by;
        for (int i = 0; i < 15; i++) q.push_back(1'b0);
        q.push_back(1'b1);
        run_pkt(q, 0, 1'b0, nd, c, ok, err, le, by, bo, da);
        checks++; if (ok !== exp_ok(q) || err !== !exp_ok(q)) begin errors++; $display("FAIL badcrc_result got ok=%b err=%b want %b/%b", ok, err, exp_ok(q), !exp_ok(q)); end
        checks++; if (ok !== 1'b0 || err !== 1'b1) begin errors++; $display("FAIL badcrc_flag got ok=%b err=%b want 0/1", ok, err); end
        checks++; if (nd !== 1) begin errors++; $display("FAIL badcrc_done got %0d pulses want 1", nd); end
    endtask

    task automatic test_merge_end();
        bitq_t q; int nd; logic [15:0] c; logic ok, err, le, bo, da; logic [BW-1:0] by;
        for (int i = 0; i < 16; i++) q.push_back(1'b0);
        run_pkt(q, 0, 1'b1, nd, c, ok, err, le, by, bo, da);
        checks++; if (c !== 16'h800D) begin errors++; $display("FAIL merge_crc got %h want 800d", c); end
        checks++; if (ok !== 1'b1 || err !== 1'b0 || nd !== 1) begin errors++; $display("FAIL merge_result got ok=%b err=%b pulses=%0d want 1/0/1", ok, err, nd); end
        checks++; if (by !== BW'(2)) begin errors++; $display("FAIL merge_bytes got %0d want 2", by); end
    endtask

    task automatic test_end_ignored();
        logic ok0, err0;
        ok0 = crc_ok; err0 = crc_error;
        pkt_end = 1'b1;
        tick();
        pkt_end = 1'b0;
        checks++; if (crc_done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL end_ignored got done=%b busy=%b want 0/0", crc_done, busy); end
        checks++; if (crc_ok !== ok0 || crc_error !== err0) begin errors++; $display("FAIL end_held got ok=%b err=%b want %b/%b", crc_ok, crc_error, ok0, err0); end
    endtask

    task automatic test_abort();
        bitq_t q; int nd, nd0; logic [15:0] c; logic ok, err, le, bo, da; logic [BW-1:0] by;
        nd0 = 0;
        pkt_start = 1'b1; tick(); pkt_start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            bit_valid = 1'b1; bit_in = 1'b1; tick(); nd0 += int'(crc_done);
        end
        bit_valid = 1'b0;
        for (int i = 0; i < 16; i++) q.push_back(1'b0);
        run_pkt(q, 0, 1'b0, nd, c, ok, err, le, by, bo, da);
        checks++; if (nd0 + nd !== 1) begin errors++; $display("FAIL abort_done got %0d pulses want 1", nd0 + nd); end
        checks++; if (ok !== 1'b1 || c !== 16'h800D) begin errors++; $display("FAIL abort_result got ok=%b crc=%h want 1/800d", ok, c); end
    endtask

    task automatic test_reset_mid();
        int nd;
        pkt_start = 1'b1; tick(); pkt_start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            bit_valid = 1'b1; bit_in = 1'($urandom_range(1)); tick();
        end
        bit_valid = 1'b0;
        checks++; if (byte_count !== BW'(1)) begin errors++; $display("FAIL rstmid_pre_bytes got %0d want 1", byte_count); end
        #2 n_rst = 1'b0;
        #1;
        checks++; if (busy !== 1'b0 || crc_done !== 1'b0 || crc_ok !== 1'b0 || crc_error !== 1'b0 || len_error_w !== 1'b0)
            begin errors++; $display("FAIL rstmid_flags got busy=%b done=%b ok=%b err=%b len=%b want all 0", busy, crc_done, crc_ok, crc_error, len_error_w); end
        checks++; if (crc_value !== 16'hFFFF || byte_count !== '0) begin errors++; $display("FAIL rstmid_state got crc=%h bytes=%0d want ffff/0", crc_value, byte_count); end
        #1 n_rst = 1'b1;
        tick();
        pkt_end = 1'b1; tick(); pkt_end = 1'b0;
        nd = int'(crc_done);
        tick(); nd += int'(crc_done);
        tick(); nd += int'(crc_done);
        checks++; if (nd !== 0 || busy !== 1'b0) begin errors++; $display("FAIL rstmid_done got pulses=%0d busy=%b want 0/0", nd, busy); end
    endtask

    task automatic test_back_to_back();
        bitq_t q; int nd; logic [15:0] c; logic ok, err, le, bo, da; logic [BW-1:0] by;
        pkt_start = 1'b1; tick(); pkt_start = 1'b0;
        for (int i = 0; i < 16; i++) begin bit_valid = 1'b1; bit_in = 1'b0; tick(); end
        bit_valid = 1'b0; pkt_end = 1'b1; tick(); pkt_end = 1'b0;
        checks++; if (crc_done !== 1'b1 || crc_ok !== 1'b1) begin errors++; $display("FAIL b2b_first got done=%b ok=%b want 1/1", crc_done, crc_ok); end
        pkt_start = 1'b1; tick(); pkt_start = 1'b0;
        checks++; if (crc_done !== 1'b0 || crc_ok !== 1'b0 || crc_error !== 1'b0 || busy !== 1'b1)
            begin errors++; $display("FAIL b2b_restart got done=%b ok=%b err=%b busy=%b want 0/0/0/1", crc_done, crc_ok, crc_error, busy); end
        checks++; if (crc_value !== 16'hFFFF || byte_count !== '0) begin errors++; $display("FAIL b2b_clear got crc=%h bytes=%0d want ffff/0", crc_value, byte_count); end
        q = make_good(3);
        run_pkt(q, 20, 1'b0, nd, c, ok, err, le, by, bo, da);
        checks++; if (ok !== exp_ok(q) || nd !== 1) begin errors++; $display("FAIL b2b_second got ok=%b pulses=%0d want %b/1", ok, nd, exp_ok(q)); end
    endtask

    task automatic test_random();
        bitq_t q; int nd, mode, pos; logic [15:0] c; logic ok, err, le, bo, da; logic [BW-1:0] by;
        for (int t = 0; t < 40; t++) begin
            q = make_good($urandom_range(0, 8));
            mode = $urandom_range(0, 3);
            if (mode == 0) begin
                pos = $urandom_range(0, q.size() - 1);
                q[pos] = ~q[pos];
            end else if (mode == 1) begin
                for (int k = $urandom_range(1, 7); k > 0; k--) q.push_back(bit'($urandom_range(1)));
            end
            run_pkt(q, 30, bit'($urandom_range(1)), nd, c, ok, err, le, by, bo, da);
            checks++; if (c !== crc_model(q)) begin errors++; $display("FAIL rand%0d_crc got %h want %h", t, c, crc_model(q)); end
            checks++; if (ok !== exp_ok(q) || err !== !exp_ok(q)) begin errors++; $display("FAIL rand%0d_result got ok=%b err=%b want %b/%b", t, ok, err, exp_ok(q), !exp_ok(q)); end
            checks++; if (by !== exp_bytes(q.size())) begin errors++; $display("FAIL rand%0d_bytes got %0d want %0d", t, by, exp_bytes(q.size())); end
            checks++; if (le !== exp_len_err(q.size())) begin errors++; $display("FAIL rand%0d_len got %b want %b", t, le, exp_len_err(q.size())); end
            checks++; if (nd !== 1 || da !== 1'b0 || bo !== 1'b1) begin errors++; $display("FAIL rand%0d_ctrl got pulses=%0d after=%b busy_ok=%b want 1/0/1", t, nd, da, bo); end
        end
    endtask

    task automatic test_byte_sat();
        bitq_t q; int nd; logic [15:0] c; logic ok, err, le, bo, da; logic [BW-1:0] by;
        q = make_good(2050);
        run_pkt(q, 0, 1'b0, nd, c, ok, err, le, by, bo, da);
        checks++; if (by !== exp_bytes(q.size())) begin errors++; $display("FAIL sat_bytes got %0d want %0d", by, exp_bytes(q.size())); end
        checks++; if (ok !== exp_ok(q) || c !== crc_model(q)) begin errors++; $display("FAIL sat_result got ok=%b crc=%h want %b/%h", ok, c, exp_ok(q), crc_model(q)); end
    endtask

`ifdef RX_CRC_LEN_CHECK_EN
    task automatic test_len_error();
        bitq_t q; int nd; logic [15:0] c; logic ok, err, le, bo, da; logic [BW-1:0] by;
        for (int i = 0; i < 12; i++) q.push_back(1'b0);
        run_pkt(q, 0, 1'b0, nd, c, ok, err, le, by, bo, da);
        checks++; if (le !== 1'b1 || err !== 1'b1 || ok !== 1'b0) begin errors++; $display("FAIL len_flags got len=%b err=%b ok=%b want 1/1/0", le, err, ok); end
        checks++; if (by !== BW'(1)) begin errors++; $display("FAIL len_bytes got %0d want 1", by); end
    endtask
`endif

    initial begin
        test_reset();
        test_zero_len();
        test_end_ignored();
        test_last_bit_one();
        test_merge_end();
        test_abort();
        test_reset_mid();
        test_back_to_back();
        test_random();
        test_byte_sat();
`ifdef RX_CRC_LEN_CHECK_EN
        test_len_error();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
